// File: rtl/cjbrisc_hw_stack_pkg.sv
//------------------------------------------------------------------------------
// Module  : cjbrisc_hw_stack_pkg
// Brief   : Shared cjbRISC stack constants and stack-operation encoding.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cjbrisc_hw_stack_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

  // Encoding matches the {push,pop} pair so decode is a direct cast.
  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic push, input logic pop);
    return stack_op_e'({push, pop});
  endfunction

endpackage

`default_nettype wire

// File: rtl/cjbrisc_hw_stack.sv
//------------------------------------------------------------------------------
// Module  : cjbrisc_hw_stack
// Brief   : Hardware LIFO with registered top-of-stack and zero read latency.
//           Macro CJBRISC_STACK_ERR_EN builds sticky overflow/underflow flags.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cjbrisc_hw_stack
  import cjbrisc_hw_stack_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf_err,
  output logic                       unf_err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [SPW-1:0]   r_sp;
  logic [WIDTH-1:0] r_dout;

  logic [SPW-1:0]   w_sp_nxt;
  logic [WIDTH-1:0] w_dout_nxt;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic             w_empty;
  logic             w_full;
  logic [SPW-1:0]   w_sp_m1;
  logic [SPW-1:0]   w_sp_m2;
  stack_op_e        w_op;

  assign w_empty = (r_sp == '0);
  assign w_full  = (r_sp == SPW'(DEPTH));
  assign w_sp_m1 = r_sp - SPW'(1);
  assign w_sp_m2 = r_sp - SPW'(2);
  assign w_op    = decode_op(push, pop);

  always_comb begin
    w_sp_nxt   = r_sp;
    w_dout_nxt = r_dout;
    w_we       = 1'b0;
    w_waddr    = r_sp[AW-1:0];
    w_ovf_set  = 1'b0;
    w_unf_set  = 1'b0;
    case (w_op)
      OP_PUSH: begin
        if (w_full) begin
          w_ovf_set = 1'b1;
        end else begin
          w_we       = 1'b1;
          w_sp_nxt   = r_sp + SPW'(1);
          w_dout_nxt = din;
        end
      end
      OP_POP: begin
        if (w_empty) begin
          w_unf_set = 1'b1;
        end else begin
          w_sp_nxt   = w_sp_m1;
          // Prefetch the entry beneath the top so dout is valid right after the pop.
          w_dout_nxt = (r_sp == SPW'(1)) ? '0 : r_mem[w_sp_m2[AW-1:0]];
        end
      end
      OP_REPLACE: begin
        w_we       = 1'b1;
        w_dout_nxt = din;
        if (w_empty) begin
          w_sp_nxt = SPW'(1);
        end else begin
          w_waddr = w_sp_m1[AW-1:0];
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_sp   <= '0;
      r_dout <= '0;
    end else begin
      r_sp   <= w_sp_nxt;
      r_dout <= w_dout_nxt;
    end
  end

  // Storage is intentionally not reset; entries are unreachable while empty.
  always_ff @(posedge Clock) begin
    if (w_we && !Reset) begin
      r_mem[w_waddr] <= din;
    end
  end

`ifdef CJBRISC_STACK_ERR_EN
  logic r_ovf_err;
  logic r_unf_err;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_ovf_err <= 1'b0;
      r_unf_err <= 1'b0;
    end else begin
      r_ovf_err <= r_ovf_err | w_ovf_set;
      r_unf_err <= r_unf_err | w_unf_set;
    end
  end

  assign ovf_err = r_ovf_err;
  assign unf_err = r_unf_err;
`else
  logic w_unused_err;
  assign w_unused_err = w_ovf_set ^ w_unf_set;
  assign ovf_err      = 1'b0;
  assign unf_err      = 1'b0;
`endif

  assign dout  = r_dout;
  assign level = r_sp;
  assign empty = w_empty;
  assign full  = w_full;

endmodule

`default_nettype wire

// File: tb/tb_cjbrisc_hw_stack.sv
//------------------------------------------------------------------------------
// Module  : tb_cjbrisc_hw_stack
// Brief   : Directed self-checking bench for cjbrisc_hw_stack.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cjbrisc_hw_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

`ifdef CJBRISC_STACK_ERR_EN
  localparam logic C_ERR = 1'b1;
`else
  localparam logic C_ERR = 1'b0;
`endif

  logic             Clock;
  logic             Reset;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [3:0]       level;
  logic             empty;
  logic             full;
  logic             ovf_err;
  logic             unf_err;

  int checks = 0;
  int errors = 0;

  cjbrisc_hw_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .push    (push),
    .pop     (pop),
    .din     (din),
    .dout    (dout),
    .level   (level),
    .empty   (empty),
    .full    (full),
    .ovf_err (ovf_err),
    .unf_err (unf_err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d,
                      input logic r);
    push  = p;
    pop   = q;
    din   = d;
    Reset = r;
    @(posedge Clock);
    #1;
    push  = 1'b0;
    pop   = 1'b0;
    Reset = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [7:0] e_dout,
                             input logic [3:0] e_level, input logic e_ovf,
                             input logic e_unf);
    check({tag, ".dout"},  dout,    e_dout);
    check({tag, ".level"}, level,   e_level);
    check({tag, ".empty"}, empty,   e_level == 4'd0);
    check({tag, ".full"},  full,    e_level == 4'd8);
    check({tag, ".ovf"},   ovf_err, e_ovf);
    check({tag, ".unf"},   unf_err, e_unf);
  endtask

  initial begin
    push = 1'b0; pop = 1'b0; din = '0; Reset = 1'b1;
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    check_state("reset", 8'h00, 4'd0, 1'b0, 1'b0);

    step(1, 0, 8'h11, 0);
    check_state("push11", 8'h11, 4'd1, 1'b0, 1'b0);
    step(1, 0, 8'h22, 0);
    step(1, 0, 8'h33, 0);
    check_state("push33", 8'h33, 4'd3, 1'b0, 1'b0);
    step(0, 0, 8'hEE, 0);
    check_state("idle", 8'h33, 4'd3, 1'b0, 1'b0);

    step(0, 1, 8'h00, 0);
    check_state("pop1", 8'h22, 4'd2, 1'b0, 1'b0);
    step(0, 1, 8'h00, 0);
    check_state("pop2", 8'h11, 4'd1, 1'b0, 1'b0);
    step(0, 1, 8'h00, 0);
    check_state("pop3", 8'h00, 4'd0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) step(1, 0, 8'hA0 + 8'(i), 0);
    check_state("fill", 8'hA7, 4'd8, 1'b0, 1'b0);
    step(1, 0, 8'hFF, 0);
    check_state("ovf", 8'hA7, 4'd8, C_ERR, 1'b0);
    step(1, 1, 8'hEE, 0);
    check_state("repl_full", 8'hEE, 4'd8, C_ERR, 1'b0);
    step(0, 1, 8'h00, 0);
    check_state("pop_full", 8'hA6, 4'd7, C_ERR, 1'b0);

    step(0, 0, 8'h00, 1);
    check_state("reset2", 8'h00, 4'd0, 1'b0, 1'b0);
    step(0, 1, 8'h00, 0);
    check_state("unf", 8'h00, 4'd0, 1'b0, C_ERR);
    step(1, 0, 8'h5A, 0);
    check_state("push5A", 8'h5A, 4'd1, 1'b0, C_ERR);
    step(1, 0, 8'h22, 0);
    step(1, 1, 8'h99, 0);
    check_state("repl", 8'h99, 4'd2, 1'b0, C_ERR);
    step(0, 1, 8'h00, 0);
    check_state("pop_repl", 8'h5A, 4'd1, 1'b0, C_ERR);

    step(0, 0, 8'h00, 1);
    step(1, 1, 8'h3C, 0);
    check_state("repl_empty", 8'h3C, 4'd1, 1'b0, 1'b0);

    step(1, 0, 8'h01, 0);
    step(1, 0, 8'h02, 0);
    step(1, 0, 8'h03, 0);
    step(1, 1, 8'hFF, 0);
    step(1, 0, 8'hFF, 0);
    step(1, 0, 8'hFF, 0);
    step(1, 0, 8'hFF, 0);
    step(1, 0, 8'hFF, 0);
    step(1, 0, 8'hFF, 0);
    step(1, 0, 8'hFF, 0);
    check_state("ovf2", 8'hFF, 4'd8, C_ERR, 1'b0);
    step(1, 0, 8'h77, 1);
    check_state("reset_push", 8'h00, 4'd0, 1'b0, 1'b0);
    step(1, 0, 8'h44, 0);
    check_state("push44", 8'h44, 4'd1, 1'b0, 1'b0);
    step(1, 0, 8'h55, 0);
    step(0, 1, 8'h00, 0);
    check_state("pop55", 8'h44, 4'd1, 1'b0, 1'b0);
    step(0, 1, 8'h00, 0);
    check_state("pop44", 8'h00, 4'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cjbrisc_hw_stack.md
CJBRISC_HW_STACK -- requirements
Module: cjbrisc_hw_stack

Interface
REQ-001 The block SHALL have the following parameters, one per line:
  WIDTH, 8, data word width in bits.
  DEPTH, 8, number of stack entries; power of two, at least 2.
REQ-002 The block SHALL have the following ports:
  Clock      input   1                     rising-edge clock
  Reset      input   1                     synchronous, active-high reset
  push       input   1                     write din on top of the stack this cycle
  pop        input   1                     remove the top entry this cycle
  din        input   WIDTH                 data to push (register-file bus from the control unit's source select)
  dout       output  WIDTH                 current top-of-stack, registered
  level      output  $clog2(DEPTH)+1       number of valid entries
  empty      output  1                     level == 0
  full       output  1                     level == DEPTH
  ovf_err    output  1                     sticky: push attempted while full
  unf_err    output  1                     sticky: pop attempted while empty
REQ-003 Reset SHALL be Reset: synchronous, active-high. The clock SHALL be Clock.

Function
REQ-004 Storage SHALL be a DEPTH x WIDTH array plus a stack pointer sp equal to level; entry sp-1 is the top.
REQ-005 dout SHALL be a flop that always equals the top entry, or 0 when empty.
- The control unit samples dout in the same cycle it asserts pop, so no read latency is allowed.
REQ-006 Push only, not full: at the edge, mem[sp] <= din, sp <= sp+1, dout <= din.
REQ-007 Pop only, not empty: at the edge, sp <= sp-1, and dout <= mem[sp-2], or 0 if the new level is 0.
REQ-008 Push and pop together, not empty: the top entry SHALL be replaced, mem[sp-1] <= din, dout <= din, sp unchanged.
REQ-009 Push and pop together while empty: the block SHALL behave as push only; unf_err is not set.
REQ-010 Push and pop together while full: the block SHALL behave as a replace (REQ-008); ovf_err is not set.
REQ-011 Push only while full: storage, sp and dout SHALL be unchanged, and ovf_err SHALL set.
REQ-012 Pop only while empty: storage, sp and dout SHALL be unchanged, and unf_err SHALL set.
REQ-013 Neither push nor pop: all state SHALL hold.
REQ-014 empty, full and level SHALL be combinational decodes of sp, valid in the same cycle as sp.
REQ-015 sp arithmetic SHALL be $clog2(DEPTH)+1 bits wide and SHALL never wrap (guarded by REQ-011 and REQ-012).

Reset
REQ-016 On Reset: sp=0, dout=0, ovf_err=0, unf_err=0; resulting outputs level=0, empty=1, full=0.
REQ-017 Reset SHALL take priority over push and pop in the same cycle.
REQ-018 Array contents SHALL NOT be cleared by reset; they are unobservable while the stack is empty.
REQ-019 A reset asserted mid-sequence SHALL discard all entries; the next push lands at index 0.

Configuration
REQ-020 When macro CJBRISC_STACK_ERR_EN is defined:
- ovf_err and unf_err SHALL be implemented as sticky flags per REQ-011 and REQ-012.
- They SHALL be cleared only by Reset.
REQ-021 When CJBRISC_STACK_ERR_EN is undefined:
- ovf_err and unf_err SHALL be tied to 0 and no error flops SHALL be built.
- Ignore-on-full and ignore-on-empty behaviour SHALL remain unchanged.

Structure
REQ-022 The shared cjbRISC package SHALL hold:
- the default WIDTH and DEPTH constants;
- the stack-operation encoding typedef (NONE, PUSH, POP, REPLACE) decoded from {push,pop}.
REQ-023 The design SHALL be a single module with no sub-modules.
- The array with its write port is inline.
- The next-state decode SHALL be one case on the operation typedef.

Verification
REQ-024 Reset, then push 0x11, 0x22, 0x33 -> after the third push, dout=0x33, level=3, empty=0.
REQ-025 From REQ-024, pop x3 -> dout sequence 0x22, 0x11, 0x00; empty=1 after the third pop; unf_err=0.
REQ-026 Push 8 values 0xA0..0xA7, then push 0xFF -> full=1, level=8, dout=0xA7, ovf_err=1 (with macro) or 0 (without).
REQ-027 Pop while empty -> level=0, dout=0, unf_err=1 (with macro); a subsequent push 0x5A gives dout=0x5A, level=1.
REQ-028 With level=2 and top 0x22, assert push=pop=1, din=0x99 -> dout=0x99, level=2; then pop gives dout=the older entry.
REQ-029 Push 3 values, then assert Reset together with push 0x77 -> level=0, dout=0, errors cleared; the next push 0x44 gives level=1, dout=0x44.
